program_counter: RTL and testbench

PROGRAM_COUNTER -- requirements
Module: program_counter

---
 rtl/program_counter.sv | 61 ++++++
 tb/tb_program_counter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/program_counter.sv
// program_counter
//   Holds the current instruction address. A new address is loaded on the
//   rising clock edge when pc_write_en is high. The alignment bits of the
//   loaded address are forced to zero. A separate flag records whether
//   those dropped bits were nonzero.
//
// Ports
//   clock        : single clock, all state changes on its rising edge
//   reset_n      : asynchronous active-low reset; deassertion is synchronized
//                  outside this block
//   pc_in_addr   : next PC value, sampled on the rising edge
//   pc_write_en  : load enable; 0 stalls the PC and the misaligned flag
//   pc_out_addr  : current PC, driven straight from the register
//   pc_plus4     : pc_out_addr + 4 modulo 2^WIDTH, combinational
//   misaligned   : registered; the last loaded address had nonzero alignment bits
module program_counter #(
  parameter int unsigned            WIDTH      = 32,
  parameter logic [WIDTH-1:0]       RESET_ADDR = 32'h0000_0000,
  parameter int unsigned            ALIGN_BITS = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pc_in_addr,
  input  logic             pc_write_en,
  output logic [WIDTH-1:0] pc_out_addr,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             misaligned
);

  // Using a mask instead of a part-select keeps ALIGN_BITS = 0 legal.
  localparam logic [WIDTH-1:0] ALIGN_MASK = {WIDTH{1'b1}} << ALIGN_BITS;
  localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(4);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             misaligned_q, misaligned_d;

  always_comb begin
    pc_d         = pc_q;
    misaligned_d = misaligned_q;
    if (pc_write_en) begin
      pc_d         = pc_in_addr & ALIGN_MASK;
      misaligned_d = |(pc_in_addr & ~ALIGN_MASK);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q         <= RESET_ADDR;
      misaligned_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign pc_out_addr = pc_q;
  // The adder has no carry out, so the top address wraps around to zero.
  assign pc_plus4    = pc_q + PC_STEP;
  assign misaligned  = misaligned_q;

endmodule

// File: tb/tb_program_counter.sv
module tb_program_counter;

  logic        clock;
  logic        reset_n;
  logic [31:0] pc_in_addr;
  logic        pc_write_en;
  logic [31:0] pc_out_addr;
  logic [31:0] pc_plus4;
  logic        misaligned;

  int checks = 0;
  int errors = 0;

  // Reference state: the address last accepted and its dropped low bits
  logic [31:0] model_pc;
  logic        model_mis;

  program_counter #(
    .WIDTH(32),
    .RESET_ADDR(32'h0000_0000),
    .ALIGN_BITS(2)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .pc_in_addr(pc_in_addr),
    .pc_write_en(pc_write_en),
    .pc_out_addr(pc_out_addr),
    .pc_plus4(pc_plus4),
    .misaligned(misaligned)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},    pc_out_addr,        model_pc);
    check({tag, ".plus4"}, pc_plus4,           model_pc + 32'd4);
    check({tag, ".mis"},   {31'd0, misaligned}, {31'd0, model_mis});
  endtask

  task automatic model_reset();
    model_pc  = 32'h0;
    model_mis = 1'b0;
  endtask

  // Drive inputs at the falling edge, then observe just after the rising edge.
  task automatic step(input logic en, input logic [31:0] addr);
    @(negedge clock);
    pc_write_en = en;
    pc_in_addr  = addr;
    @(posedge clock);
    #1;
    if (reset_n && en) begin
      model_pc  = addr - (addr % 32'd4);
      model_mis = (addr % 32'd4) != 32'd0;
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    pc_write_en = 1'b0;
    pc_in_addr  = 32'h0;
    model_reset();
    #15;
    check_all("reset_init");

    @(negedge clock);
    reset_n = 1'b1;

    // Get to pc=0x40, then pull reset in the middle of the cycle
    step(1'b1, 32'h40);
    check_all("load_40");
    #4;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    @(negedge clock);
    reset_n = 1'b1;

    // Basic loads
    step(1'b1, 32'h0);
    check_all("load_0");
    step(1'b1, 32'h4);
    check_all("load_4");
    check("load_4.plus4_lit", pc_plus4, 32'h8);

    // Stall for three clocks, then load
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h100);
      check("stall.pc", pc_out_addr, 32'h4);
    end
    step(1'b1, 32'h100);
    check_all("after_stall");

    // Misalignment and its hold during a stall
    step(1'b1, 32'h103);
    check_all("mis_103");
    check("mis_103.lit", {31'd0, misaligned}, 32'd1);
    step(1'b0, 32'h8);
    check_all("mis_hold");
    step(1'b1, 32'h104);
    check_all("mis_104");

    // Top address and wrap of pc_plus4
    step(1'b1, 32'hFFFF_FFFC);
    check_all("wrap");
    check("wrap.plus4_lit", pc_plus4, 32'h0);

    // Reset held across a rising edge with a pending load
    @(negedge clock);
    reset_n     = 1'b0;
    pc_write_en = 1'b1;
    pc_in_addr  = 32'h200;
    model_reset();
    @(posedge clock);
    #1;
    check_all("reset_prec");
    @(negedge clock);
    reset_n = 1'b1;
    step(1'b1, 32'h208);
    check_all("first_after_reset");

    // Random traffic against the reference model
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 3) != 0), $urandom);
      check_all("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
